// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: single-outstanding memory port shared by the I-cache and the
// D-cache. It arbitrates reads, writes and miss-repair notices onto one port.
//
// Handshake semantics used throughout:
//   - Upstream requests (ic_req, dc_rreq, dc_wreq) are levels. The requester holds
//     each one until its completion pulse (ic_rvalid, dc_rvalid or dc_wack).
//   - Downstream issue strobes (raddr_valid, waddr_valid) are combinational
//     1-cycle pulses in the grant cycle. Address and data are valid only while
//     the strobe is high, and are 0 at all other times.
//   - dc_repair is a level that stays high until dc_repair_ack is sampled high.
//   - repair_resolved pulses on the cycle after that acknowledge.
module mem_req_arbiter #(
   parameter int unsigned RD_TIMEOUT = 255
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ic_req,
   input  logic [31:0]  ic_addr,
   output logic [31:0]  ic_rdata,
   output logic         ic_rvalid,
   input  logic         dc_rreq,
   input  logic [31:0]  dc_raddr,
   output logic [31:0]  dc_rdata,
   output logic         dc_rvalid,
   input  logic         dc_wreq,
   input  logic [31:0]  dc_waddr,
   input  logic [255:0] dc_wdata,
   input  logic [31:0]  dc_wmask,
   output logic         dc_wack,
   output logic         dc_repair,
   output logic [31:0]  dc_repair_addr,
   output logic         dc_repair_wr,
   input  logic         dc_repair_ack,
   output logic         raddr_valid,
   output logic [31:0]  raddr,
   output logic         waddr_valid,
   output logic [31:0]  waddr,
   output logic [255:0] wdata,
   output logic [31:0]  wmask,
   output logic         repair_resolved,
   input  logic [31:0]  rdata,
   input  logic         rdata_valid,
   input  logic         read_miss_repair,
   input  logic         write_miss_repair,
   input  logic [31:0]  missed_addr,
   output logic         rd_timeout_err,
   output logic [1:0]   dbg_state_o
);

   localparam logic [7:0] TMO = 8'(RD_TIMEOUT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_DONE = 2'd2,
      REPAIR  = 2'd3
   } state_e;

   state_e       state_q, state_d;
   logic [7:0]   cnt_q, cnt_d;
   logic         rr_dc_q, rr_dc_d;        // 1: D-cache read wins the next tie
   logic         src_dc_q, src_dc_d;      // source of the read in flight
   logic         rep_pend_q, rep_pend_d;
   logic [31:0]  rep_addr_q, rep_addr_d;
   logic         rep_wr_q, rep_wr_d;
   logic         resolved_q, resolved_d;

   logic         can_grant, grant_wr, grant_rd, pick_dc;
   logic         rd_hit, rd_tmo, rd_end;

   // Grant qualification. rst_n gates the grant so that outputs stay 0
   // while reset is held.
   always_comb begin
      can_grant = rst_n && (state_q == IDLE) && !rep_pend_q;
      grant_wr  = can_grant && dc_wreq;
      grant_rd  = can_grant && !dc_wreq && (ic_req || dc_rreq);
      pick_dc   = dc_rreq && (!ic_req || rr_dc_q);
      rd_hit    = (state_q == RD_WAIT) && rdata_valid;
      rd_tmo    = (state_q == RD_WAIT) && !rdata_valid && (cnt_q == TMO);
      rd_end    = rd_hit || rd_tmo;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic. A pending repair is taken only from IDLE, and it beats
   // every grant.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (rep_pend_q)    state_d = REPAIR;
            else if (grant_wr) state_d = WR_DONE;
            else if (grant_rd) state_d = RD_WAIT;
         end
         RD_WAIT: if (rd_end)        state_d = IDLE;
         WR_DONE:                    state_d = IDLE;
         REPAIR:  if (dc_repair_ack) state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   // Datapath next-state logic: the timeout counter, round-robin pointer,
   // latched read source and repair record. A new miss pulse always
   // overwrites the repair record, and a write miss wins over a read miss.
   always_comb begin
      cnt_d      = (state_q == RD_WAIT) ? cnt_q + 8'd1 : 8'd0;
      rr_dc_d    = rr_dc_q;
      src_dc_d   = src_dc_q;
      rep_pend_d = rep_pend_q;
      rep_addr_d = rep_addr_q;
      rep_wr_d   = rep_wr_q;
      resolved_d = (state_q == REPAIR) && dc_repair_ack;
      if (grant_rd) begin
         src_dc_d = pick_dc;
         rr_dc_d  = !pick_dc;
      end
      if (write_miss_repair) begin
         rep_pend_d = 1'b1;
         rep_addr_d = missed_addr;
         rep_wr_d   = 1'b1;
      end else if (read_miss_repair) begin
         rep_pend_d = 1'b1;
         rep_addr_d = missed_addr;
         rep_wr_d   = 1'b0;
      end else if (resolved_d) begin
         rep_pend_d = 1'b0;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= 8'd0;
         rr_dc_q    <= 1'b0;
         src_dc_q   <= 1'b0;
         rep_pend_q <= 1'b0;
         rep_addr_q <= 32'd0;
         rep_wr_q   <= 1'b0;
         resolved_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         rr_dc_q    <= rr_dc_d;
         src_dc_q   <= src_dc_d;
         rep_pend_q <= rep_pend_d;
         rep_addr_q <= rep_addr_d;
         rep_wr_q   <= rep_wr_d;
         resolved_q <= resolved_d;
      end
   end

   // Output decode. Read data passes straight through to the latched source,
   // and it is forced to 0 on a timeout.
   always_comb begin
      raddr_valid     = grant_rd;
      raddr           = grant_rd ? (pick_dc ? dc_raddr : ic_addr) : 32'd0;
      waddr_valid     = grant_wr;
      waddr           = grant_wr ? dc_waddr : 32'd0;
      wdata           = grant_wr ? dc_wdata : 256'd0;
      wmask           = grant_wr ? dc_wmask : 32'd0;
      ic_rvalid       = rd_end && !src_dc_q;
      dc_rvalid       = rd_end && src_dc_q;
      ic_rdata        = (rd_hit && !src_dc_q) ? rdata : 32'd0;
      dc_rdata        = (rd_hit && src_dc_q) ? rdata : 32'd0;
      rd_timeout_err  = rd_tmo;
      dc_wack         = (state_q == WR_DONE);
      dc_repair       = (state_q == REPAIR);
      dc_repair_addr  = (state_q == REPAIR) ? rep_addr_q : 32'd0;
      dc_repair_wr    = (state_q == REPAIR) && rep_wr_q;
      repair_resolved = resolved_q;
      dbg_state_o     = state_q;
   end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed test of mem_req_arbiter. Inputs are driven 1 time
// unit after the rising edge, and outputs are sampled on the falling edge.
module tb_mem_req_arbiter;

   logic         clk, rst_n;
   logic         ic_req, dc_rreq, dc_wreq, dc_repair_ack;
   logic [31:0]  ic_addr, dc_raddr, dc_waddr, dc_wmask, rdata, missed_addr;
   logic [255:0] dc_wdata;
   logic         rdata_valid, read_miss_repair, write_miss_repair;
   logic [31:0]  ic_rdata, dc_rdata, dc_repair_addr, raddr, waddr, wmask;
   logic [255:0] wdata;
   logic         ic_rvalid, dc_rvalid, dc_wack, dc_repair, dc_repair_wr;
   logic         raddr_valid, waddr_valid, repair_resolved, rd_timeout_err;
   logic [1:0]   dbg_state_o;

   int n_checks = 0;
   int n_fail   = 0;
   logic [32:0] exp_q[$];   // {is_dc, data} of each expected read completion

   mem_req_arbiter #(.RD_TIMEOUT(255)) dut (
      .clk(clk), .rst_n(rst_n),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid),
      .dc_rreq(dc_rreq), .dc_raddr(dc_raddr), .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid),
      .dc_wreq(dc_wreq), .dc_waddr(dc_waddr), .dc_wdata(dc_wdata), .dc_wmask(dc_wmask),
      .dc_wack(dc_wack), .dc_repair(dc_repair), .dc_repair_addr(dc_repair_addr),
      .dc_repair_wr(dc_repair_wr), .dc_repair_ack(dc_repair_ack),
      .raddr_valid(raddr_valid), .raddr(raddr), .waddr_valid(waddr_valid), .waddr(waddr),
      .wdata(wdata), .wmask(wmask), .repair_resolved(repair_resolved),
      .rdata(rdata), .rdata_valid(rdata_valid), .read_miss_repair(read_miss_repair),
      .write_miss_repair(write_miss_repair), .missed_addr(missed_addr),
      .rd_timeout_err(rd_timeout_err), .dbg_state_o(dbg_state_o)
   );

   // Clock generation.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something hangs.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic sb_check(input string tag);
      logic [32:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 1'b1, 1'b0);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_ic_rvalid"}, ic_rvalid, !e[32]);
         check({tag, "_dc_rvalid"}, dc_rvalid, e[32]);
         check({tag, "_rdata"}, e[32] ? dc_rdata : ic_rdata, e[31:0]);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_raddr_valid"}, raddr_valid, 1'b0);
      check({tag, "_raddr"}, raddr, 32'd0);
      check({tag, "_waddr_valid"}, waddr_valid, 1'b0);
      check({tag, "_wdata"}, wdata, 256'd0);
      check({tag, "_rvalids"}, {ic_rvalid, dc_rvalid, ic_rdata, dc_rdata}, 66'd0);
      check({tag, "_misc"}, {dc_wack, dc_repair, dc_repair_addr, repair_resolved, rd_timeout_err}, 36'd0);
   endtask

   initial begin
      int tmo_idx;
      rst_n = 1'b0;
      ic_req = 0; dc_rreq = 0; dc_wreq = 0; dc_repair_ack = 0;
      ic_addr = 0; dc_raddr = 0; dc_waddr = 0; dc_wmask = 0; dc_wdata = 0;
      rdata = 0; rdata_valid = 0; read_miss_repair = 0; write_miss_repair = 0;
      missed_addr = 0;

      // Reset state: all outputs stay 0 even while requests are present.
      tick();
      ic_req = 1; dc_wreq = 1; dc_wdata = {8{32'hA5A5A5A5}}; dc_wmask = 32'hFFFFFFFF;
      ic_addr = 32'h0000_0100;
      sample();
      check_idle_outputs("reset");
      check("reset_state", dbg_state_o, 2'd0);
      tick();
      ic_req = 0; dc_wreq = 0;
      rst_n = 1'b1;

      // Simultaneous reads from reset: the I-cache goes first, then the D-cache.
      tick();
      ic_req = 1; ic_addr = 32'h0000_0100; dc_rreq = 1; dc_raddr = 32'h0000_0200;
      sample();
      check("t1_ic_grant_v", raddr_valid, 1'b1);
      check("t1_ic_grant_a", raddr, 32'h0000_0100);
      tick();
      sample();
      check("t1_wait_no_grant", raddr_valid, 1'b0);
      check("t1_wait_state", dbg_state_o, 2'd1);
      tick();
      rdata = 32'hDEADBEEF; rdata_valid = 1;
      exp_q.push_back({1'b0, 32'hDEADBEEF});
      sample();
      sb_check("t1_ic_done");
      tick();
      ic_req = 0; rdata_valid = 0;
      sample();
      check("t1_dc_grant_v", raddr_valid, 1'b1);
      check("t1_dc_grant_a", raddr, 32'h0000_0200);
      tick();
      rdata = 32'h12345678; rdata_valid = 1;
      exp_q.push_back({1'b1, 32'h12345678});
      sample();
      sb_check("t1_dc_done");
      tick();
      dc_rreq = 0; rdata_valid = 0;

      // The write beats both reads. dc_wack comes one cycle later, then the
      // reads run round-robin.
      dc_wreq = 1; dc_waddr = 32'h0000_3000; dc_wdata = {8{32'hCAFEF00D}};
      dc_wmask = 32'hFFFFFFFF;
      ic_req = 1; ic_addr = 32'h0000_0140; dc_rreq = 1; dc_raddr = 32'h0000_0240;
      sample();
      check("t2_waddr_valid", waddr_valid, 1'b1);
      check("t2_no_raddr_valid", raddr_valid, 1'b0);
      check("t2_waddr", waddr, 32'h0000_3000);
      check("t2_wdata", wdata, {8{32'hCAFEF00D}});
      check("t2_wmask", wmask, 32'hFFFFFFFF);
      check("t2_wack_early", dc_wack, 1'b0);
      tick();
      sample();
      check("t2_wack", dc_wack, 1'b1);
      check("t2_no_issue_wr_done", {waddr_valid, raddr_valid}, 2'b00);
      tick();
      dc_wreq = 0;
      sample();
      check("t2_rd1_addr", {raddr_valid, raddr}, {1'b1, 32'h0000_0140});
      check("t2_wack_gone", dc_wack, 1'b0);
      tick();
      rdata = 32'h1111_2222; rdata_valid = 1;
      exp_q.push_back({1'b0, 32'h1111_2222});
      sample();
      sb_check("t2_ic_done");
      tick();
      ic_req = 0; rdata_valid = 0;
      sample();
      check("t2_rd2_addr", {raddr_valid, raddr}, {1'b1, 32'h0000_0240});
      tick();
      rdata = 32'h3333_4444; rdata_valid = 1;
      exp_q.push_back({1'b1, 32'h3333_4444});
      sample();
      sb_check("t2_dc_done");
      tick();
      dc_rreq = 0; rdata_valid = 0;

      // A read-miss repair that arrives during RD_WAIT waits for the read to
      // finish. While REPAIR is active, no grants are made.
      ic_req = 1; ic_addr = 32'h0000_0180;
      sample();
      check("t3_grant", {raddr_valid, raddr}, {1'b1, 32'h0000_0180});
      tick();
      read_miss_repair = 1; missed_addr = 32'h0000_1040;
      sample();
      check("t3_no_repair_in_rd", dc_repair, 1'b0);
      tick();
      read_miss_repair = 0; rdata = 32'h5555_6666; rdata_valid = 1;
      exp_q.push_back({1'b0, 32'h5555_6666});
      sample();
      sb_check("t3_rd_done");
      check("t3_no_repair_yet", dc_repair, 1'b0);
      tick();
      ic_req = 0; rdata_valid = 0; dc_rreq = 1; dc_raddr = 32'h0000_0280;
      sample();
      check("t3_pending_blocks", raddr_valid, 1'b0);
      tick();
      sample();
      check("t3_repair", {dc_repair, dc_repair_addr, dc_repair_wr}, {1'b1, 32'h0000_1040, 1'b0});
      check("t3_repair_no_grant", raddr_valid, 1'b0);
      check("t3_repair_state", dbg_state_o, 2'd3);
      tick();
      dc_repair_ack = 1;
      sample();
      check("t3_held_no_grant", raddr_valid, 1'b0);
      check("t3_resolved_early", repair_resolved, 1'b0);
      tick();
      dc_repair_ack = 0;
      sample();
      check("t3_resolved", repair_resolved, 1'b1);
      check("t3_repair_drop", dc_repair, 1'b0);
      check("t3_grant_after", {raddr_valid, raddr}, {1'b1, 32'h0000_0280});
      tick();
      sample();
      check("t3_resolved_pulse", repair_resolved, 1'b0);
      tick();
      rdata = 32'h7777_8888; rdata_valid = 1;
      exp_q.push_back({1'b1, 32'h7777_8888});
      sample();
      sb_check("t3_dc_done");
      tick();
      dc_rreq = 0; rdata_valid = 0;

      // When both miss types arrive together, write wins. A later read miss
      // then overwrites the pending record.
      write_miss_repair = 1; read_miss_repair = 1; missed_addr = 32'h0000_2000;
      tick();
      write_miss_repair = 0; read_miss_repair = 0;
      tick();
      sample();
      check("t3b_wr_prec", {dc_repair, dc_repair_addr, dc_repair_wr}, {1'b1, 32'h0000_2000, 1'b1});
      tick();
      read_miss_repair = 1; missed_addr = 32'h0000_3040;
      tick();
      read_miss_repair = 0;
      sample();
      check("t3b_overwrite", {dc_repair, dc_repair_addr, dc_repair_wr}, {1'b1, 32'h0000_3040, 1'b0});
      tick();
      dc_repair_ack = 1;
      tick();
      dc_repair_ack = 0;
      sample();
      check("t3b_resolved", {repair_resolved, dc_repair}, 2'b10);
      tick();

      // Read timeout. The pulse appears 255 cycles into RD_WAIT, and rdata
      // is forced to 0.
      ic_req = 1; ic_addr = 32'h0000_01C0; rdata = 32'hDEADBEEF;
      sample();
      check("t4_grant", {raddr_valid, raddr}, {1'b1, 32'h0000_01C0});
      tick();
      tmo_idx = -1;
      for (int i = 0; i < 300; i++) begin
         sample();
         if (rd_timeout_err || ic_rvalid) begin
            tmo_idx = i;
            break;
         end
         tick();
      end
      check("t4_tmo_cycle", tmo_idx, 255);
      check("t4_tmo_err", rd_timeout_err, 1'b1);
      check("t4_tmo_rvalid", {ic_rvalid, dc_rvalid}, 2'b10);
      check("t4_tmo_rdata", ic_rdata, 32'd0);
      tick();
      ic_req = 0; rdata_valid = 1;
      sample();
      check("t4_late_ignored", {ic_rvalid, dc_rvalid, rd_timeout_err}, 3'b000);
      check("t4_idle", dbg_state_o, 2'd0);
      tick();
      rdata_valid = 0;

      // Reset during RD_WAIT clears outputs at once and restores I-cache
      // priority. (The last grant was to the I-cache, so the D-cache would
      // otherwise win.)
      ic_req = 1; ic_addr = 32'h0000_0111; dc_rreq = 1; dc_raddr = 32'h0000_0222;
      sample();
      check("t5_pre_grant", {raddr_valid, raddr}, {1'b1, 32'h0000_0222});
      tick();
      #2;
      rst_n = 0;
      #1;
      check_idle_outputs("t5_in_reset");
      check("t5_reset_state", dbg_state_o, 2'd0);
      tick();
      rst_n = 1; rdata = 32'hBAD0BAD0; rdata_valid = 1;
      sample();
      check("t5_late_ignored", {ic_rvalid, dc_rvalid}, 2'b00);
      check("t5_ic_priority", {raddr_valid, raddr}, {1'b1, 32'h0000_0111});
      tick();
      rdata = 32'h0BAD_CAFE;
      exp_q.push_back({1'b0, 32'h0BAD_CAFE});
      sample();
      sb_check("t5_ic_done");
      tick();
      ic_req = 0; dc_rreq = 0; rdata_valid = 0;
      tick();

      check("sb_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
